fpa_sched: RTL and testbench
============================

Name: fpa_sched

Overview:
- Round-robin scheduler that shares one multi-cycle 32-bit floating-point adder (fpa) among NUM_REQ requesters.
- Accepts one operand pair at a time over a valid/ready handshake, drives the adder's start/operand interface, and waits for its out_valid.
- Returns the result, tagged with the requester index, over a valid/ready response channel.
- Guards against a hung adder with a watchdog that substitutes a quiet NaN.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- TIMEOUT, 64, max cycles spent in WAIT before the watchdog fires (>=2)
- ID_W, $clog2(NUM_REQ), width of requester index

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_x  in  32*NUM_REQ  operand X, requester i at [32i+31:32i]
- req_y  in  32*NUM_REQ  operand Y, same packing
- req_ready  out  NUM_REQ  one-hot grant/accept
- resp_valid  out  1  result valid
- resp_ready  in  1  result consumer ready
- resp_result  out  32  IEEE-754 single result
- resp_id  out  ID_W  index of requester that owns resp_result
- resp_timeout  out  1  qualifies resp_result as watchdog substitute
- fpa_start  out  1  one-cycle start pulse to adder
- fpa_x  out  32  operand X to adder, held stable ISSUE..end of WAIT
- fpa_y  out  32  operand Y to adder
- fpa_result  in  32  adder result
- fpa_out_valid  in  1  adder result valid
- timeout_err  out  1  sticky watchdog flag
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst sampled high at posedge):
  - state=IDLE, rr_ptr=0, wait counter=0.
  - All outputs 0: req_ready, resp_valid, resp_result, resp_id, resp_timeout, fpa_start, fpa_x, fpa_y, timeout_err, busy.
  - Reset mid-operation abandons the transaction with no response; the adder's late out_valid is ignored because state is IDLE.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Grant = first i with req_valid[i], searched from rr_ptr upward with wrap modulo NUM_REQ.
  - req_ready = one-hot grant, combinational from req_valid and rr_ptr. It is 0 outside IDLE and 0 while rst is high.
  - On valid&ready: register req_x/req_y of the granted requester into fpa_x/fpa_y, store the grant index into resp_id, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - fpa_start=1 for exactly this cycle.
  - Clear the wait counter, go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - If fpa_out_valid: resp_result<=fpa_result, resp_timeout<=0, go to RESP.
  - Else if counter==TIMEOUT-1: resp_result<=32'h7FC00000, resp_timeout<=1, timeout_err<=1, go to RESP.
  - fpa_out_valid together with the timeout: the real result wins, no error.
- RESP:
  - resp_valid=1; resp_result, resp_id and resp_timeout stay stable until resp_ready.
  - On resp_valid&resp_ready: rr_ptr<=(resp_id+1) mod NUM_REQ, go to IDLE.
  - No bypass: the next accept occurs at the earliest one cycle after the response handshake.
- fpa_out_valid outside WAIT is ignored.
- The scheduler never inspects operand values. NaN, zero and infinity handling belongs to the adder.
- Latency:
  - accept at cycle T, fpa_start at T+1.
  - Adder asserts out_valid at T+1+L, so resp_valid is at T+2+L.
- timeout_err clears only on rst.

Decomposition:
- Shared package fpa_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - constants FP_QNAN=32'h7FC00000, FP_POS_Z, FP_NEG_Z, FP_POS_I, FP_NEG_I, shared with fpa
- Sub-module rr_arb (parameter N): inputs req[N], ptr; output one-hot gnt and encoded index. Purely combinational, unit-tested separately.

Test Plan:
- Single request: req0 X=32'h3F800000, Y=32'h40000000; stub adder with L=3 -> fpa_start one cycle after accept, resp_valid 5 cycles after accept, resp_result=32'h40400000, resp_id=0, resp_timeout=0.
- Fairness: all 4 req_valid held high, resp_ready=1 -> grant order 0,1,2,3,0. rr_ptr wraps from 3 to 0. Exactly one req_ready bit high per accept.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid -> resp_result/resp_id stable, req_ready all 0, no new fpa_start.
- Watchdog: stub never asserts out_valid, TIMEOUT=64 -> response 32'h7FC00000 with resp_timeout=1, timeout_err=1 persisting across later good transactions until rst.
- Race: out_valid arrives on the final WAIT cycle (counter=TIMEOUT-1) -> real result returned, timeout_err=0.
- Reset mid-WAIT: rst for 1 cycle, stub out_valid arrives 2 cycles later -> no resp_valid, all outputs 0, next grant to requester 0.

Source files
------------

// File: rtl/fpa_pkg.sv
// Shared types and IEEE-754 single-precision constants for the adder
// scheduler and the adder itself.
package fpa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;
  localparam logic [31:0] FP_POS_Z = 32'h0000_0000;
  localparam logic [31:0] FP_NEG_Z = 32'h8000_0000;
  localparam logic [31:0] FP_POS_I = 32'h7F80_0000;
  localparam logic [31:0] FP_NEG_I = 32'hFF80_0000;

endpackage

// File: rtl/fpa_sched_rr_arb.sv
// Combinational round-robin arbiter: first asserted request at or above
// ptr, wrapping modulo N, as a one-hot grant plus its encoded index.
module rr_arb #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] idx
);

  logic found_s;
  int   pos_s;

  // Rotating priority search starting at ptr
  always_comb begin
    gnt     = '0;
    idx     = '0;
    found_s = 1'b0;
    pos_s   = 0;
    for (int k = 0; k < N; k++) begin
      pos_s = int'(ptr) + k;
      if (pos_s >= N) begin
        pos_s = pos_s - N;
      end else begin
        pos_s = pos_s;
      end
      if (!found_s && req[pos_s]) begin
        gnt[pos_s] = 1'b1;
        idx        = ID_W'(pos_s);
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/fpa_sched.sv
// Round-robin scheduler sharing one multi-cycle FP adder among NUM_REQ
// requesters, with a watchdog that substitutes a quiet NaN on a hung adder.
module fpa_sched #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_x,
  input  logic [32*NUM_REQ-1:0]   req_y,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [31:0]             resp_result,
  output logic [ID_W-1:0]         resp_id,
  output logic                    resp_timeout,
  output logic                    fpa_start,
  output logic [31:0]             fpa_x,
  output logic [31:0]             fpa_y,
  input  logic [31:0]             fpa_result,
  input  logic                    fpa_out_valid,
  output logic                    timeout_err,
  output logic                    busy
);
  import fpa_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  state_e               state_r;
  state_e               state_nxt_s;
  logic [ID_W-1:0]      rr_ptr_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [NUM_REQ-1:0]   gnt_s;
  logic [ID_W-1:0]      gnt_idx_s;
  logic                 accept_s;
  logic                 timeout_hit_s;
  logic [31:0]          sel_x_s;
  logic [31:0]          sel_y_s;

  rr_arb #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_r),
    .gnt (gnt_s),
    .idx (gnt_idx_s)
  );

  assign timeout_hit_s = (cnt_r == CNT_W'(TIMEOUT - 1));

  // Operand mux driven by the one-hot grant
  always_comb begin
    sel_x_s = 32'h0000_0000;
    sel_y_s = 32'h0000_0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_s[i]) begin
        sel_x_s = req_x[32*i +: 32];
        sel_y_s = req_y[32*i +: 32];
      end else begin
        sel_x_s = sel_x_s;
        sel_y_s = sel_y_s;
      end
    end
  end

  // Next-state and state-decoded outputs; grants are suppressed during reset
  always_comb begin
    state_nxt_s = state_r;
    req_ready   = '0;
    accept_s    = 1'b0;
    fpa_start   = 1'b0;
    resp_valid  = 1'b0;
    busy        = 1'b1;
    case (state_r)
      IDLE: begin
        busy = 1'b0;
        if (!rst && (|gnt_s)) begin
          req_ready   = gnt_s;
          accept_s    = 1'b1;
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        fpa_start   = 1'b1;
        state_nxt_s = WAIT;
      end
      WAIT: begin
        if (fpa_out_valid || timeout_hit_s) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and watchdog registers; a real result beats a same-cycle timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      rr_ptr_r     <= '0;
      cnt_r        <= '0;
      fpa_x        <= 32'h0000_0000;
      fpa_y        <= 32'h0000_0000;
      resp_result  <= 32'h0000_0000;
      resp_id      <= '0;
      resp_timeout <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            fpa_x   <= sel_x_s;
            fpa_y   <= sel_y_s;
            resp_id <= gnt_idx_s;
          end
        end
        ISSUE: begin
          cnt_r <= '0;
        end
        WAIT: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (fpa_out_valid) begin
            resp_result  <= fpa_result;
            resp_timeout <= 1'b0;
          end else if (timeout_hit_s) begin
            resp_result  <= FP_QNAN;
            resp_timeout <= 1'b1;
            timeout_err  <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            if (resp_id == ID_W'(NUM_REQ - 1)) begin
              rr_ptr_r <= '0;
            end else begin
              rr_ptr_r <= resp_id + ID_W'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpa_sched.sv
// Directed self-checking bench for fpa_sched with a latency-programmable
// adder stub returning a bench-chosen result.
module tb_fpa_sched;

  localparam int N   = 4;
  localparam int TMO = 64;
  localparam int IW  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_x;
  logic [32*N-1:0] req_y;
  logic [N-1:0]    req_ready;
  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     resp_result;
  logic [IW-1:0]   resp_id;
  logic            resp_timeout;
  logic            fpa_start;
  logic [31:0]     fpa_x;
  logic [31:0]     fpa_y;
  logic [31:0]     fpa_result;
  logic            fpa_out_valid;
  logic            timeout_err;
  logic            busy;

  int          checks = 0;
  int          errors = 0;
  int          stub_lat = 3;
  logic        stub_never = 1'b0;
  logic [31:0] stub_res = 32'h0000_0000;
  logic        stub_pend = 1'b0;
  int          stub_cnt = 0;
  int          n;

  always #5 clk = ~clk;

  fpa_sched #(.NUM_REQ(N), .TIMEOUT(TMO), .ID_W(IW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_x         (req_x),
    .req_y         (req_y),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_result   (resp_result),
    .resp_id       (resp_id),
    .resp_timeout  (resp_timeout),
    .fpa_start     (fpa_start),
    .fpa_x         (fpa_x),
    .fpa_y         (fpa_y),
    .fpa_result    (fpa_result),
    .fpa_out_valid (fpa_out_valid),
    .timeout_err   (timeout_err),
    .busy          (busy)
  );

  // Adder stub: out_valid exactly stub_lat cycles after the start cycle
  always @(posedge clk) begin
    if (fpa_start) begin
      stub_pend <= 1'b1;
      stub_cnt  <= 1;
    end else if (stub_pend) begin
      if (stub_cnt == stub_lat) stub_pend <= 1'b0;
      else stub_cnt <= stub_cnt + 1;
    end
  end
  assign fpa_out_valid = stub_pend && !stub_never && (stub_cnt == stub_lat);
  assign fpa_result    = stub_res;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    check_eq("resp_seen", 32'(resp_valid), 32'd1);
  endtask

  // Accept from id, check the start pulse and operands, then wait for the response.
  // cyc counts cycles from accept+2 to resp_valid.
  task automatic do_txn(input int id, output int cyc);
    #1;
    check_eq("grant", 32'(req_ready), 32'd1 << id);
    tick();
    check_eq("start_hi", 32'(fpa_start), 32'd1);
    check_eq("fpa_x", fpa_x, req_x[32*id +: 32]);
    check_eq("fpa_y", fpa_y, req_y[32*id +: 32]);
    tick();
    check_eq("start_lo", 32'(fpa_start), 32'd0);
    wait_resp(cyc);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 4'hF;
    resp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_x[32*i +: 32] = 32'h4100_0000 + 32'(i);
      req_y[32*i +: 32] = 32'hC100_0000 + 32'(i);
    end
    req_x[31:0] = 32'h3F80_0000;
    req_y[31:0] = 32'h4000_0000;
    tick();
    tick();
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_fpa_x", fpa_x, 32'd0);
    check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);

    // Single request, L=3: resp_valid 5 cycles after accept
    req_valid = 4'b0001;
    rst       = 1'b0;
    stub_lat  = 3;
    stub_res  = 32'h4040_0000;
    do_txn(0, n);
    req_valid = 4'b0000;
    check_eq("single_lat", 32'(n), 32'd3);
    check_eq("single_res", resp_result, 32'h4040_0000);
    check_eq("single_id", 32'(resp_id), 32'd0);
    check_eq("single_tmo", 32'(resp_timeout), 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check_eq("single_idle", 32'(busy), 32'd0);

    // Fairness from a fresh pointer: 0,1,2,3,0
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    req_valid  = 4'hF;
    resp_ready = 1'b1;
    stub_lat   = 1;
    for (int k = 0; k < 5; k++) begin
      stub_res = 32'h5000_0000 + 32'(k);
      do_txn(k % 4, n);
      check_eq("fair_lat", 32'(n), 32'd1);
      check_eq("fair_id", 32'(resp_id), 32'(k % 4));
      check_eq("fair_res", resp_result, 32'h5000_0000 + 32'(k));
      tick();
    end

    // Backpressure: id 2 (pointer now 1, only 2 requesting)
    resp_ready = 1'b0;
    req_valid  = 4'b0100;
    stub_lat   = 2;
    stub_res   = 32'h1234_5678;
    do_txn(2, n);
    req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_eq("bp_valid", 32'(resp_valid), 32'd1);
      check_eq("bp_res", resp_result, 32'h1234_5678);
      check_eq("bp_id", 32'(resp_id), 32'd2);
      check_eq("bp_ready", 32'(req_ready), 32'd0);
      check_eq("bp_start", 32'(fpa_start), 32'd0);
    end
    req_valid  = 4'b0000;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Watchdog: adder never answers, id 1 (pointer 3 wraps through 0)
    req_valid  = 4'b0010;
    stub_never = 1'b1;
    do_txn(1, n);
    req_valid = 4'b0000;
    check_eq("wd_lat", 32'(n), 32'd64);
    check_eq("wd_res", resp_result, 32'h7FC0_0000);
    check_eq("wd_tmo", 32'(resp_timeout), 32'd1);
    check_eq("wd_err", 32'(timeout_err), 32'd1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Good transaction after timeout: sticky error stays set
    stub_never = 1'b0;
    stub_lat   = 2;
    stub_res   = 32'h3F80_0000;
    req_valid  = 4'b1000;
    do_txn(3, n);
    req_valid = 4'b0000;
    check_eq("post_wd_tmo", 32'(resp_timeout), 32'd0);
    check_eq("post_wd_res", resp_result, 32'h3F80_0000);
    check_eq("post_wd_err", 32'(timeout_err), 32'd1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("err_cleared", 32'(timeout_err), 32'd0);

    // Race: out_valid on the last WAIT cycle, real result wins
    stub_lat  = 64;
    stub_res  = 32'hC0A0_0000;
    req_valid = 4'b0001;
    do_txn(0, n);
    req_valid = 4'b0000;
    check_eq("race_lat", 32'(n), 32'd64);
    check_eq("race_res", resp_result, 32'hC0A0_0000);
    check_eq("race_tmo", 32'(resp_timeout), 32'd0);
    check_eq("race_err", 32'(timeout_err), 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Reset mid-WAIT: late out_valid ignored, pointer back to 0
    stub_lat  = 3;
    stub_res  = 32'hDEAD_BEEF;
    req_valid = 4'b0010;
    #1;
    check_eq("rw_grant", 32'(req_ready), 32'd2);
    tick();
    tick();
    req_valid = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check_eq("rw_no_resp", 32'(resp_valid), 32'd0);
      check_eq("rw_busy", 32'(busy), 32'd0);
      tick();
    end
    check_eq("rw_res", resp_result, 32'd0);
    check_eq("rw_id", 32'(resp_id), 32'd0);
    check_eq("rw_fpa_x", fpa_x, 32'd0);
    check_eq("rw_fpa_y", fpa_y, 32'd0);
    check_eq("rw_tmo", 32'(resp_timeout), 32'd0);
    check_eq("rw_start", 32'(fpa_start), 32'd0);
    req_valid = 4'hF;
    #1;
    check_eq("rw_next_grant", 32'(req_ready), 32'd1);
    req_valid = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
